// File: rtl/regfile_checker_pkg.sv
// Shared state encoding and default sizing for the register-file checker.
package regfile_checker_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      SCAN,
      DRAIN,
      DONE
   } state_t;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_NREGS  = 32;
   localparam int DEF_RD_LAT = 1;
   localparam int DEF_CNT_W  = 32;

endpackage

// File: rtl/regfile_checker_if.sv
// Control, read-port and result signals of the checker; master is the checker side.
interface regfile_checker_if
   import regfile_checker_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREGS = DEF_NREGS,
   parameter int CNT_W = DEF_CNT_W
);
   localparam int AW = $clog2(NREGS);

   logic             start;
   logic             abort;
   logic [CNT_W-1:0] run_cycles;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic [WIDTH-1:0] exp_data;
   logic             exp_care;
   logic             busy;
   logic             done;
   logic             pass;
   logic [AW:0]      mismatch_count;
   logic             fail_valid;
   logic [AW-1:0]    fail_idx;
   logic [WIDTH-1:0] fail_data;

   modport master (
      input  start, abort, run_cycles, rd_data, exp_data, exp_care,
      output rd_addr, busy, done, pass, mismatch_count, fail_valid, fail_idx, fail_data
   );

   modport slave (
      output start, abort, run_cycles, rd_data, exp_data, exp_care,
      input  rd_addr, busy, done, pass, mismatch_count, fail_valid, fail_idx, fail_data
   );

endinterface

// File: rtl/regfile_checker_delay_pipe.sv
// Delays {valid, index} by the read-port latency so each compare sees its own index.
module checker_delay_pipe #(
   parameter int AW    = 5,
   parameter int DEPTH = 1
) (
   input  logic          clk,
   input  logic          rstb,
   input  logic          flush,
   input  logic          vld_in,
   input  logic [AW-1:0] idx_in,
   output logic          vld_out,
   output logic [AW-1:0] idx_out
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_ctrl;
         assign unused_ctrl = &{1'b0, clk, rstb, flush};
         assign vld_out     = vld_in;
         assign idx_out     = idx_in;
      end else begin : g_pipe
         logic          vld_p [DEPTH];
         logic [AW-1:0] idx_p [DEPTH];

         // flush kills every in-flight compare so an aborted scan reports nothing more
         always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
               for (int i = 0; i < DEPTH; i++) vld_p[i] <= 1'b0;
            end else begin
               vld_p[0] <= vld_in & ~flush;
               for (int i = 1; i < DEPTH; i++) vld_p[i] <= vld_p[i-1] & ~flush;
            end
         end

         always_ff @(posedge clk) begin
            idx_p[0] <= idx_in;
            for (int i = 1; i < DEPTH; i++) idx_p[i] <= idx_p[i-1];
         end

         assign vld_out = vld_p[DEPTH-1];
         assign idx_out = idx_p[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/regfile_checker.sv
// Waits run_cycles, scans every register through the read port, compares against
// expected values and reports each mismatch plus an overall pass/fail.
module regfile_checker
   import regfile_checker_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NREGS  = DEF_NREGS,
   parameter int RD_LAT = DEF_RD_LAT,
   parameter int CNT_W  = DEF_CNT_W
) (
   input logic               clk,
   input logic               rstb,
   regfile_checker_if.master bus
);

   localparam int            AW         = $clog2(NREGS);
   localparam int            MW         = AW + 1;
   localparam int            DRAIN_INIT = (RD_LAT > 0) ? RD_LAT - 1 : 0;
   localparam logic [AW-1:0] LAST_IDX   = AW'(NREGS - 1);

   state_t           state, next_state;
   logic [CNT_W-1:0] run_cnt;
   logic [AW-1:0]    scan_idx;
   logic [1:0]       drain_cnt;
   logic [MW-1:0]    mis_cnt;
   logic             done_q;
   logic             start_ok;
   logic             scan_vld;
   logic             cmp_vld;
   logic [AW-1:0]    cmp_idx;
   logic             mismatch;

   function automatic logic [MW-1:0] sat_inc(input logic [MW-1:0] v);
      if (v >= MW'(NREGS)) return v;
      return v + MW'(1);
   endfunction

   assign start_ok = bus.start && !bus.abort && (state == IDLE || state == DONE);

   always_comb begin
      next_state = state;
      if (bus.abort) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE, DONE: if (bus.start) next_state = (bus.run_cycles == '0) ? SCAN : RUN;
            RUN:        if (run_cnt <= CNT_W'(1)) next_state = SCAN;
            SCAN:       if (scan_idx == LAST_IDX) next_state = (RD_LAT == 0) ? DONE : DRAIN;
            DRAIN:      if (drain_cnt == 2'd0) next_state = DONE;
            default:    next_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state     <= IDLE;
         run_cnt   <= '0;
         scan_idx  <= '0;
         drain_cnt <= '0;
         mis_cnt   <= '0;
         done_q    <= 1'b0;
      end else begin
         state  <= next_state;
         done_q <= (next_state == DONE) && (state != DONE);

         if (start_ok)           run_cnt <= bus.run_cycles;
         else if (state == RUN)  run_cnt <= run_cnt - CNT_W'(1);

         if (state == SCAN && next_state == SCAN) scan_idx <= scan_idx + AW'(1);
         else                                     scan_idx <= '0;

         if (state == SCAN)                         drain_cnt <= 2'(DRAIN_INIT);
         else if (state == DRAIN && drain_cnt != 0) drain_cnt <= drain_cnt - 2'd1;

         if (start_ok)      mis_cnt <= '0;
         else if (mismatch) mis_cnt <= sat_inc(mis_cnt);
      end
   end

   // compare stage: index delayed to line up with the read data
   assign scan_vld = (state == SCAN) && !bus.abort;

   checker_delay_pipe #(
      .AW    (AW),
      .DEPTH (RD_LAT)
   ) u_delay (
      .clk     (clk),
      .rstb    (rstb),
      .flush   (bus.abort),
      .vld_in  (scan_vld),
      .idx_in  (scan_idx),
      .vld_out (cmp_vld),
      .idx_out (cmp_idx)
   );

   assign mismatch = cmp_vld && !bus.abort && bus.exp_care && (bus.rd_data != bus.exp_data);

   assign bus.rd_addr        = (state == SCAN) ? scan_idx : '0;
   assign bus.busy           = (state == RUN) || (state == SCAN) || (state == DRAIN);
   assign bus.done           = done_q;
   assign bus.pass           = (state == DONE) && (mis_cnt == '0);
   assign bus.mismatch_count = mis_cnt;
   assign bus.fail_valid     = mismatch;
   assign bus.fail_idx       = mismatch ? cmp_idx : '0;
   assign bus.fail_data      = mismatch ? bus.rd_data : '0;

endmodule

// File: tb/tb_regfile_checker.sv
// Scoreboard bench: expected mismatches queued from the register model, popped on fail_valid.
module tb_regfile_checker;
   import regfile_checker_pkg::*;

   localparam int WIDTH = 32;
   localparam int NREGS = 32;
   localparam int CNT_W = 32;

   typedef struct {
      int               idx;
      logic [WIDTH-1:0] data;
   } fail_t;

   logic clk = 1'b0;
   logic rstb;
   always #5 clk = ~clk;

   regfile_checker_if #(.WIDTH(WIDTH), .NREGS(NREGS), .CNT_W(CNT_W)) bus1 ();
   regfile_checker_if #(.WIDTH(WIDTH), .NREGS(NREGS), .CNT_W(CNT_W)) bus0 ();

   regfile_checker #(.WIDTH(WIDTH), .NREGS(NREGS), .RD_LAT(1), .CNT_W(CNT_W)) dut1 (
      .clk (clk), .rstb (rstb), .bus (bus1)
   );
   regfile_checker #(.WIDTH(WIDTH), .NREGS(NREGS), .RD_LAT(0), .CNT_W(CNT_W)) dut0 (
      .clk (clk), .rstb (rstb), .bus (bus0)
   );

   logic [WIDTH-1:0] rf_val  [NREGS];
   logic [WIDTH-1:0] rf_exp  [NREGS];
   logic             rf_care [NREGS];

   // register file with one cycle of read latency for dut1, combinational for dut0
   always @(posedge clk) begin
      bus1.rd_data  <= rf_val[bus1.rd_addr];
      bus1.exp_data <= rf_exp[bus1.rd_addr];
      bus1.exp_care <= rf_care[bus1.rd_addr];
   end
   assign bus0.rd_data  = rf_val[bus0.rd_addr];
   assign bus0.exp_data = rf_exp[bus0.rd_addr];
   assign bus0.exp_care = rf_care[bus0.rd_addr];

   int    n_vec = 0;
   int    n_err = 0;
   fail_t q1[$];
   fail_t q0[$];
   int    busy_cnt1 = 0, done_cnt1 = 0, fail_cnt1 = 0;
   int    done_cnt0 = 0, fail_cnt0 = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (bus1.busy) busy_cnt1++;
      if (bus1.done) done_cnt1++;
      if (bus1.fail_valid) begin
         fail_t e;
         fail_cnt1++;
         if (q1.size() == 0) begin
            chk("fail1_unexpected_idx", 64'(bus1.fail_idx), 64'(NREGS));
         end else begin
            e = q1.pop_front();
            chk("fail1_idx", 64'(bus1.fail_idx), 64'(e.idx));
            chk("fail1_data", 64'(bus1.fail_data), 64'(e.data));
         end
      end
   end

   always @(negedge clk) begin
      if (bus0.done) done_cnt0++;
      if (bus0.fail_valid) begin
         fail_t e;
         fail_cnt0++;
         if (q0.size() == 0) begin
            chk("fail0_unexpected_idx", 64'(bus0.fail_idx), 64'(NREGS));
         end else begin
            e = q0.pop_front();
            chk("fail0_idx", 64'(bus0.fail_idx), 64'(e.idx));
            chk("fail0_data", 64'(bus0.fail_data), 64'(e.data));
         end
      end
   end

   task automatic fill_match();
      for (int k = 0; k < NREGS; k++) begin
         rf_val[k]  = $urandom;
         rf_exp[k]  = rf_val[k];
         rf_care[k] = 1'b1;
      end
   endtask

   task automatic push_expected(input bit to_dut0);
      fail_t e;
      for (int k = 0; k < NREGS; k++) begin
         if (rf_care[k] && rf_val[k] != rf_exp[k]) begin
            e.idx  = k;
            e.data = rf_val[k];
            if (to_dut0) q0.push_back(e);
            else         q1.push_back(e);
         end
      end
   endtask

   task automatic run1(input string tag, input logic [CNT_W-1:0] rc, input int exp_mc,
                       input int exp_busy);
      int b0, d0, f0;
      push_expected(1'b0);
      b0 = busy_cnt1; d0 = done_cnt1; f0 = fail_cnt1;
      bus1.run_cycles = rc;
      bus1.start      = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      for (int i = 0; i < int'(rc) + NREGS + 20; i++) begin
         @(negedge clk);
         if (bus1.done) break;
      end
      chk({tag, "_done"}, 64'(bus1.done), 64'd1);
      chk({tag, "_pass"}, 64'(bus1.pass), 64'(exp_mc == 0));
      chk({tag, "_mismatch_count"}, 64'(bus1.mismatch_count), 64'(exp_mc));
      repeat (3) @(negedge clk);
      chk({tag, "_busy_cycles"}, 64'(busy_cnt1 - b0), 64'(exp_busy));
      chk({tag, "_done_pulses"}, 64'(done_cnt1 - d0), 64'd1);
      chk({tag, "_fail_pulses"}, 64'(fail_cnt1 - f0), 64'(exp_mc));
      chk({tag, "_sb_left"}, 64'(q1.size()), 64'd0);
      chk({tag, "_pass_hold"}, 64'(bus1.pass), 64'(exp_mc == 0));
      chk({tag, "_mc_hold"}, 64'(bus1.mismatch_count), 64'(exp_mc));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, 64'(bus1.busy), 64'd0);
      chk({tag, "_done"}, 64'(bus1.done), 64'd0);
      chk({tag, "_pass"}, 64'(bus1.pass), 64'd0);
      chk({tag, "_fail_valid"}, 64'(bus1.fail_valid), 64'd0);
      chk({tag, "_mismatch_count"}, 64'(bus1.mismatch_count), 64'd0);
      chk({tag, "_fail_idx"}, 64'(bus1.fail_idx), 64'd0);
      chk({tag, "_fail_data"}, 64'(bus1.fail_data), 64'd0);
      chk({tag, "_rd_addr"}, 64'(bus1.rd_addr), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, d0, f0, cnt;
      bus1.start = 1'b0; bus1.abort = 1'b0; bus1.run_cycles = '0;
      bus0.start = 1'b0; bus0.abort = 1'b0; bus0.run_cycles = '0;
      fill_match();
      rstb = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      chk("por_dut0_busy", 64'(bus0.busy), 64'd0);
      rstb = 1'b1;
      @(negedge clk);

      // all registers match, long run phase
      fill_match();
      run1("all_match", 1000, 0, 1000 + NREGS + 1);

      // single mismatch at register 11
      fill_match();
      rf_val[11] = 32'hFFFF_FFF0;
      rf_exp[11] = 32'hFFFF_FFF8;
      run1("reg11", 5, 1, 5 + NREGS + 1);

      // don't-care upper registers carry differing data
      fill_match();
      for (int k = 18; k < NREGS; k++) begin
         rf_care[k] = 1'b0;
         rf_val[k]  = $urandom;
         rf_exp[k]  = rf_val[k] ^ 32'h5A5A_0001;
      end
      run1("dont_care", 7, 0, 7 + NREGS + 1);

      // first and last index plus one in the middle
      fill_match();
      rf_exp[0]  = ~rf_val[0];
      rf_exp[16] = rf_val[16] ^ 32'h8000_0000;
      rf_exp[31] = rf_val[31] + 32'd1;
      run1("edges", 1, 3, 1 + NREGS + 1);

      // every register differs: count reaches NREGS
      fill_match();
      for (int k = 0; k < NREGS; k++) rf_exp[k] = ~rf_val[k];
      run1("all_bad", 2, NREGS, 2 + NREGS + 1);

      // zero latency, zero run cycles, mismatch on the last index
      fill_match();
      rf_val[31] = rf_val[31] ^ 32'h1;
      push_expected(1'b1);
      d0 = done_cnt0; f0 = fail_cnt0;
      bus0.run_cycles = '0;
      bus0.start      = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      chk("lat0_busy_first", 64'(bus0.busy), 64'd1);
      chk("lat0_addr_first", 64'(bus0.rd_addr), 64'd0);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         cnt++;
         if (bus0.done) break;
      end
      chk("lat0_done_delay", 64'(cnt), 64'd32);
      chk("lat0_mismatch_count", 64'(bus0.mismatch_count), 64'd1);
      chk("lat0_pass", 64'(bus0.pass), 64'd0);
      chk("lat0_addr_idle", 64'(bus0.rd_addr), 64'd0);
      repeat (2) @(negedge clk);
      chk("lat0_done_pulses", 64'(done_cnt0 - d0), 64'd1);
      chk("lat0_fail_pulses", 64'(fail_cnt0 - f0), 64'd1);
      chk("lat0_sb_left", 64'(q0.size()), 64'd0);

      // abort during scan at index 5; mismatch at 20 is never reached
      fill_match();
      rf_val[20] = rf_val[20] ^ 32'h1;
      d0 = done_cnt1; f0 = fail_cnt1;
      bus1.run_cycles = 4;
      bus1.start      = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus1.rd_addr == 5) break;
      end
      chk("abort_reach_idx5", 64'(bus1.rd_addr), 64'd5);
      bus1.abort = 1'b1;
      bus1.start = 1'b1;
      @(negedge clk);
      bus1.abort = 1'b0;
      bus1.start = 1'b0;
      chk("abort_idle", 64'(bus1.busy), 64'd0);
      chk("abort_addr", 64'(bus1.rd_addr), 64'd0);
      repeat (40) @(negedge clk);
      chk("abort_no_done", 64'(done_cnt1 - d0), 64'd0);
      chk("abort_no_fail", 64'(fail_cnt1 - f0), 64'd0);
      rf_val[20] = rf_exp[20];
      rf_val[7]  = rf_val[7] ^ 32'h0001_0000;
      run1("after_abort", 2, 1, 2 + NREGS + 1);

      // reset in the middle of the run phase
      fill_match();
      d0 = done_cnt1;
      bus1.run_cycles = 50;
      bus1.start      = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      repeat (10) @(negedge clk);
      chk("midrun_busy", 64'(bus1.busy), 64'd1);
      rstb = 1'b0;
      #1;
      check_reset_outputs("midrun_rst");
      @(negedge clk);
      rstb = 1'b1;
      repeat (60) @(negedge clk);
      chk("midrun_no_done", 64'(done_cnt1 - d0), 64'd0);
      chk("midrun_idle", 64'(bus1.busy), 64'd0);

      // start held high throughout: restarts must not happen while busy
      b0 = busy_cnt1; d0 = done_cnt1;
      bus1.run_cycles = 3;
      bus1.start      = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (bus1.done) break;
      end
      bus1.start = 1'b0;
      chk("held_done", 64'(bus1.done), 64'd1);
      chk("held_pass", 64'(bus1.pass), 64'd1);
      repeat (3) @(negedge clk);
      chk("held_busy_cycles", 64'(busy_cnt1 - b0), 64'(3 + NREGS + 1));
      chk("held_done_pulses", 64'(done_cnt1 - d0), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_checker.md
REGFILE_CHECKER -- requirements
Module: regfile_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of checked registers.
REQ-002 SHALL have parameter NREGS, default 32, number of registers scanned (2..256).
REQ-003 SHALL have parameter RD_LAT, default 1, read-port latency in cycles (0..3).
REQ-004 SHALL have parameter CNT_W, default 32, width of the run-cycle counter.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rstb  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a run-then-check sequence.
REQ-008 SHALL have port abort  input  1  return to IDLE from any state.
REQ-009 SHALL have port run_cycles  input  CNT_W  clock cycles to wait before scanning; sampled on accepted start.
REQ-010 SHALL have port rd_addr  output  clog2(NREGS)  register index driven to the DUT register-file read port.
REQ-011 SHALL have port rd_data  input  WIDTH  register value, valid RD_LAT cycles after rd_addr.
REQ-012 SHALL have port exp_data  input  WIDTH  expected value for rd_addr; same latency as rd_data.
REQ-013 SHALL have port exp_care  input  1  1 = compare; 0 = don't-care register; same latency as rd_data.
REQ-014 SHALL have port busy  output  1  high in RUN, SCAN and DRAIN.
REQ-015 SHALL have port done  output  1  one-cycle pulse on entry to DONE.
REQ-016 SHALL have port pass  output  1  high in DONE when mismatch_count == 0.
REQ-017 SHALL have port mismatch_count  output  clog2(NREGS)+1  compared registers that differed.
REQ-018 SHALL have port fail_valid  output  1  one-cycle pulse per mismatch, with fail_idx and fail_data.
REQ-019 SHALL have port fail_idx  output  clog2(NREGS)  index of the mismatching register.
REQ-020 SHALL have port fail_data  output  WIDTH  observed value of the mismatching register.

Function
REQ-021 SHALL implement states IDLE, RUN, SCAN, DRAIN, DONE.
REQ-022 IDLE: start=1 SHALL load run counter with run_cycles, clear mismatch_count, go to RUN; run_cycles=0 SHALL go directly to SCAN.
REQ-023 RUN: counter SHALL decrement once per cycle; transition to SCAN SHALL occur in the cycle the counter reaches 1.
REQ-024 SCAN: rd_addr SHALL step 0,1,..,NREGS-1, one per cycle; after NREGS-1 is issued, go to DRAIN (RD_LAT>0) or DONE (RD_LAT=0).
REQ-025 DRAIN: SHALL last exactly RD_LAT cycles so the last issued index is compared, then go to DONE.
REQ-026 Compare for index k SHALL occur RD_LAT cycles after rd_addr=k, using an internal delayed copy of k.
REQ-027 When exp_care=1 and rd_data != exp_data, fail_valid SHALL pulse in that cycle with fail_idx=k, fail_data=rd_data, and mismatch_count SHALL increment by 1 the next cycle.
REQ-028 When exp_care=0 no compare SHALL occur for that index.
REQ-029 DONE: done SHALL pulse in the first DONE cycle; pass and mismatch_count SHALL hold until the next accepted start.
REQ-030 start SHALL be accepted only in IDLE or DONE; it SHALL be ignored while busy.
REQ-031 abort SHALL have priority over start and any transition, forcing IDLE next cycle, suppressing done, and invalidating in-flight compares.
REQ-032 rd_addr SHALL be 0 outside SCAN.
REQ-033 mismatch_count SHALL never wrap; maximum value is NREGS.

Reset
REQ-034 rstb low SHALL asynchronously force IDLE, counters 0, rd_addr 0, delay pipeline empty.
REQ-035 While reset is asserted, busy, done, pass, fail_valid, mismatch_count, fail_idx and fail_data SHALL be 0.
REQ-036 Reset asserted mid-SCAN SHALL discard all partial results; no done pulse SHALL follow deassertion.

Structure
REQ-037 The state enumeration and default parameter constants SHALL live in a shared package regfile_checker_pkg.
REQ-038 The RD_LAT-deep delay of {valid, index} SHALL be a sub-module checker_delay_pipe; RD_LAT=0 is a pass-through.

Verification
REQ-039 NREGS=32, RD_LAT=1, run_cycles=1000, all data matching -> busy 1000+32+1 cycles, done pulse, pass=1, mismatch_count=0.
REQ-040 Register 11 reads 0xFFFFFFF0, expected 0xFFFFFFF8 -> single fail_valid with fail_idx=11, fail_data=0xFFFFFFF0; mismatch_count=1; pass=0.
REQ-041 exp_care=0 for indices 18..31 carrying random data; all others matching -> zero fail_valid pulses, pass=1.
REQ-042 run_cycles=0, RD_LAT=0 -> SCAN starts the cycle after start; done 32 cycles later.
REQ-043 abort at scan index 5, then start -> no done from the first run; second run reports only its own mismatches.
REQ-044 rstb pulsed low mid-RUN; start held high during SCAN -> all outputs 0 during reset, second start ignored while busy.
